// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory read
// handshake, buffers one word under a decode stall and redirects on taken
// branches/jumps. A redirect that arrives while an access is still
// outstanding is parked in r_tgt until that access completes and is dropped.
`timescale 1ns/1ps
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        PC_SRC_SEL,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_INSTRUCTION,
    output logic        IF_ID_VALID
);

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic        r_hold_valid;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_tgt_nxt;
    logic        w_hold_valid_nxt;
    logic [31:0] w_hold_pc_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_ifid_pc_nxt;
    logic [31:0] w_ifid_pc4_nxt;
    logic [31:0] w_ifid_instr_nxt;
    logic        w_ifid_valid_nxt;

    logic        w_read;
    logic        w_done;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_hold_pc4;

    // Request whenever nothing is buffered; reset forces the request low at once.
    assign w_read     = RESET & ~r_hold_valid;
    assign w_done     = w_read & ~IMEM_BUSYWAIT;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_hold_pc4 = r_hold_pc + 32'd4;

    assign IMEM_READ         = w_read;
    assign IMEM_ADDR         = r_pc;
    assign IF_ID_PC          = r_ifid_pc;
    assign IF_ID_PC4         = r_ifid_pc4;
    assign IF_ID_INSTRUCTION = r_ifid_instr;
    assign IF_ID_VALID       = r_ifid_valid;

    // Next-state and next-register computation; everything holds by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_tgt_nxt        = r_tgt;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_pc_nxt    = r_hold_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;

        case (r_state)
            S_FETCH: begin
                if (PC_SRC_SEL) begin
                    // Redirect wins over stall; any word completing now is wrong-path.
                    w_ifid_pc_nxt    = 32'd0;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_valid_nxt = 1'b0;
                    w_hold_valid_nxt = 1'b0;
                    if (w_read && IMEM_BUSYWAIT) begin
                        // Address must stay put until the outstanding access finishes.
                        w_tgt_nxt   = BRANCH_TARGET;
                        w_state_nxt = S_DISCARD;
                    end else begin
                        w_pc_nxt = BRANCH_TARGET;
                    end
                end else if (STALL) begin
                    if (w_done) begin
                        w_hold_pc_nxt    = r_pc;
                        w_hold_instr_nxt = IMEM_READDATA;
                        w_hold_valid_nxt = 1'b1;
                        w_pc_nxt         = w_pc_plus4;
                    end
                end else if (r_hold_valid) begin
                    w_ifid_pc_nxt    = r_hold_pc;
                    w_ifid_pc4_nxt   = w_hold_pc4;
                    w_ifid_instr_nxt = r_hold_instr;
                    w_ifid_valid_nxt = 1'b1;
                    w_hold_valid_nxt = 1'b0;
                end else if (w_done) begin
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_pc4_nxt   = w_pc_plus4;
                    w_ifid_instr_nxt = IMEM_READDATA;
                    w_ifid_valid_nxt = 1'b1;
                    w_pc_nxt         = w_pc_plus4;
                end else begin
                    w_ifid_pc_nxt    = 32'd0;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_valid_nxt = 1'b0;
                end
            end
            S_DISCARD: begin
                if (!STALL) begin
                    w_ifid_pc_nxt    = 32'd0;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_valid_nxt = 1'b0;
                end
                if (PC_SRC_SEL) begin
                    w_tgt_nxt = BRANCH_TARGET;
                end
                if (w_done) begin
                    w_pc_nxt    = PC_SRC_SEL ? BRANCH_TARGET : r_tgt;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State, PC and IF/ID register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_VECTOR;
            r_hold_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    // Payload registers; only meaningful while their qualifying flag/state is set.
    always_ff @(posedge CLK) begin
        r_tgt        <= w_tgt_nxt;
        r_hold_pc    <= w_hold_pc_nxt;
        r_hold_instr <= w_hold_instr_nxt;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table with a scoreboard
// of expected IF/ID contents, plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        PC_SRC_SEL = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'd0;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_INSTRUCTION;
    logic        IF_ID_VALID;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall;
        logic        sel;
        logic [31:0] tgt;
        logic        busy;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    vec_t  vecs[$];
    ifid_t sb[$];

    instruction_fetch_unit dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .PC_SRC_SEL        (PC_SRC_SEL),
        .BRANCH_TARGET     (BRANCH_TARGET),
        .IMEM_READDATA     (IMEM_READDATA),
        .IMEM_BUSYWAIT     (IMEM_BUSYWAIT),
        .IMEM_READ         (IMEM_READ),
        .IMEM_ADDR         (IMEM_ADDR),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_PC4         (IF_ID_PC4),
        .IF_ID_INSTRUCTION (IF_ID_INSTRUCTION),
        .IF_ID_VALID       (IF_ID_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign IMEM_READDATA = mem_word(IMEM_ADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sl, input logic [31:0] tg, input logic bz,
                       input logic rd, input logic [31:0] ad, input logic vl, input logic [31:0] pc);
        vec_t v;
        v.stall = st; v.sel = sl; v.tgt = tg; v.busy = bz;
        v.exp_read = rd; v.exp_addr = ad; v.exp_valid = vl; v.exp_pc = pc;
        vecs.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"},  {31'd0, IMEM_READ}, 32'd0);
        chk({tag, "_addr"},  IMEM_ADDR, 32'd0);
        chk({tag, "_valid"}, {31'd0, IF_ID_VALID}, 32'd0);
        chk({tag, "_pc"},    IF_ID_PC, 32'd0);
        chk({tag, "_pc4"},   IF_ID_PC4, 32'd0);
        chk({tag, "_instr"}, IF_ID_INSTRUCTION, NOP);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   stall sel tgt            busy  read addr           valid pc
        add(0, 0, 32'h0,          0,   1, 32'h0000_0000, 1, 32'h0000_0000); // 0-wait stream
        add(0, 0, 32'h0,          0,   1, 32'h0000_0004, 1, 32'h0000_0004);
        add(0, 0, 32'h0,          1,   1, 32'h0000_0008, 0, 32'h0);         // 3-cycle miss
        add(0, 0, 32'h0,          1,   1, 32'h0000_0008, 0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h0000_0008, 0, 32'h0);
        add(0, 0, 32'h0,          0,   1, 32'h0000_0008, 1, 32'h0000_0008);
        add(1, 0, 32'h0,          0,   1, 32'h0000_000C, 1, 32'h0000_0008); // stall, 0xC buffered
        add(1, 0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_0008);
        add(0, 0, 32'h0,          0,   0, 32'h0000_0010, 1, 32'h0000_000C); // buffer drains
        add(0, 0, 32'h0,          0,   1, 32'h0000_0010, 1, 32'h0000_0010);
        add(0, 1, 32'h0000_0100,  1,   1, 32'h0000_0014, 0, 32'h0);         // redirect mid-miss
        add(0, 0, 32'h0,          1,   1, 32'h0000_0014, 0, 32'h0);
        add(0, 0, 32'h0,          0,   1, 32'h0000_0014, 0, 32'h0);         // dropped word
        add(0, 0, 32'h0,          0,   1, 32'h0000_0100, 1, 32'h0000_0100);
        add(1, 0, 32'h0,          0,   1, 32'h0000_0104, 1, 32'h0000_0100); // 0x104 buffered
        add(1, 1, 32'h0000_0200,  0,   0, 32'h0000_0108, 0, 32'h0);         // redirect clears buffer
        add(0, 0, 32'h0,          0,   1, 32'h0000_0200, 1, 32'h0000_0200);
        add(0, 1, 32'h0000_0300,  1,   1, 32'h0000_0204, 0, 32'h0);         // discard again
        add(1, 1, 32'h0000_0400,  1,   1, 32'h0000_0204, 0, 32'h0);         // newer target wins
        add(0, 0, 32'h0,          0,   1, 32'h0000_0204, 0, 32'h0);
        add(0, 0, 32'h0,          0,   1, 32'h0000_0400, 1, 32'h0000_0400);
        add(0, 1, 32'hFFFF_FFFC,  0,   1, 32'h0000_0404, 0, 32'h0);         // redirect on a hit
        add(0, 0, 32'h0,          0,   1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC); // PC+4 wraps
        add(0, 0, 32'h0,          0,   1, 32'h0000_0000, 1, 32'h0000_0000);
        add(1, 0, 32'h0,          1,   1, 32'h0000_0004, 1, 32'h0000_0000); // stall during miss
        add(0, 0, 32'h0,          0,   1, 32'h0000_0004, 1, 32'h0000_0004);

        // Reset asserted from time zero.
        #12;
        check_reset_outputs("por");

        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            ifid_t e;
            STALL         = vecs[i].stall;
            PC_SRC_SEL    = vecs[i].sel;
            BRANCH_TARGET = vecs[i].tgt;
            IMEM_BUSYWAIT = vecs[i].busy;
            e.valid = vecs[i].exp_valid;
            e.pc    = vecs[i].exp_valid ? vecs[i].exp_pc : 32'd0;
            e.pc4   = vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'd0;
            e.instr = vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP;
            sb.push_back(e);
            #1;
            chk($sformatf("v%0d_read", i), {31'd0, IMEM_READ}, {31'd0, vecs[i].exp_read});
            chk($sformatf("v%0d_addr", i), IMEM_ADDR, vecs[i].exp_addr);
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL v%0d_scoreboard: queue empty", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_valid", i), {31'd0, IF_ID_VALID}, {31'd0, e.valid});
                chk($sformatf("v%0d_pc", i),    IF_ID_PC, e.pc);
                chk($sformatf("v%0d_pc4", i),   IF_ID_PC4, e.pc4);
                chk($sformatf("v%0d_instr", i), IF_ID_INSTRUCTION, e.instr);
            end
            @(negedge CLK);
        end
        STALL = 1'b0;
        PC_SRC_SEL = 1'b0;

        // Asynchronous reset in the middle of a miss at 0x8.
        IMEM_BUSYWAIT = 1'b1;
        #1;
        chk("miss_read", {31'd0, IMEM_READ}, 32'd1);
        chk("miss_addr", IMEM_ADDR, 32'h0000_0008);
        #1;
        RESET = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge CLK);
        #1;
        check_reset_outputs("held");
        @(negedge CLK);
        RESET = 1'b1;
        IMEM_BUSYWAIT = 1'b0;
        #1;
        chk("rel_read", {31'd0, IMEM_READ}, 32'd1);
        chk("rel_addr", IMEM_ADDR, 32'h0000_0000);
        @(posedge CLK);
        #1;
        chk("rel_valid", {31'd0, IF_ID_VALID}, 32'd1);
        chk("rel_pc",    IF_ID_PC, 32'h0000_0000);
        chk("rel_pc4",   IF_ID_PC4, 32'h0000_0004);
        chk("rel_instr", IF_ID_INSTRUCTION, mem_word(32'h0000_0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
